nios_simple_irq_ctrl: RTL and testbench



---
 rtl/nios_simple_irq_pkg.sv | 17 +
 rtl/nios_simple_irq_ctrl_if.sv | 27 ++
 rtl/nios_simple_irq_prio_enc.sv | 21 ++
 rtl/nios_simple_irq_ctrl.sv | 119 +++++++++++
 tb/tb_nios_simple_irq_ctrl.sv | 297 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/nios_simple_irq_pkg.sv
// Shared constants for the nios_simple interrupt aggregator: register map,
// vector layout and the fixed internal register width.
package nios_simple_irq_pkg;

   localparam int unsigned MAX_IRQ          = 16;
   localparam int unsigned VECTOR_VALID_BIT = 15;

   localparam logic [2:0] ADDR_PENDING  = 3'd0;
   localparam logic [2:0] ADDR_MASK     = 3'd1;
   localparam logic [2:0] ADDR_STATUS   = 3'd2;
   localparam logic [2:0] ADDR_VECTOR   = 3'd3;
   localparam logic [2:0] ADDR_EDGE_SEL = 3'd4;
   localparam logic [2:0] ADDR_FORCE    = 3'd5;

   typedef logic [MAX_IRQ-1:0] irq_vec_t;

endpackage

// File: rtl/nios_simple_irq_ctrl_if.sv
// Avalon-MM slave bus of the interrupt aggregator; the CPU side uses the
// master modport, the controller the slave modport.
interface nios_simple_irq_ctrl_if;

   logic [2:0]  address;
   logic        chipselect;
   logic        write_n;
   logic [15:0] writedata;
   logic [15:0] readdata;

   modport master (
      output address,
      output chipselect,
      output write_n,
      output writedata,
      input  readdata
   );

   modport slave (
      input  address,
      input  chipselect,
      input  write_n,
      input  writedata,
      output readdata
   );

endinterface

// File: rtl/nios_simple_irq_prio_enc.sv
// Combinational lowest-index-first priority encoder used to build the
// interrupt VECTOR register.
module nios_simple_irq_prio_enc
   import nios_simple_irq_pkg::*;
(
   input  irq_vec_t   req_i,
   output logic       valid_o,
   output logic [3:0] idx_o
);

   // Scan downwards so the last hit, i.e. the lowest set index, wins.
   always_comb begin
      idx_o = '0;
      for (int i = MAX_IRQ - 1; i >= 0; i--) begin
         if (req_i[i]) idx_o = 4'(i);
      end
   end

   assign valid_o = |req_i;

endmodule

// File: rtl/nios_simple_irq_ctrl.sv
// Avalon-MM interrupt aggregator: latches source irqs, masks them and drives
// one registered irq. Define IRQ_CTRL_EDGE_EN to add per-source edge capture.
module nios_simple_irq_ctrl
   import nios_simple_irq_pkg::*;
#(
   parameter int unsigned NUM_IRQ = 8
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [NUM_IRQ-1:0]    irq_in,
   nios_simple_irq_ctrl_if.slave bus,
   output logic                  irq
);

   logic [NUM_IRQ-1:0] irq_in_q;
   logic [NUM_IRQ-1:0] hw_pend_q, hw_pend_d;
   logic [NUM_IRQ-1:0] soft_pend_q, soft_pend_d;
   logic [NUM_IRQ-1:0] mask_q, mask_d;
   logic [NUM_IRQ-1:0] wdata, w1c, frc_set;
   logic [15:0]        readdata_q, readdata_d;
   logic               irq_q, irq_d;
   logic               wr_en, wr_pend, wr_mask, wr_force;
   irq_vec_t           pending, status, edge_sel_rd;
   logic               vec_valid;
   logic [3:0]         vec_idx;
   logic               unused_wdata;

   assign wr_en    = bus.chipselect & ~bus.write_n;
   assign wr_pend  = wr_en && (bus.address == ADDR_PENDING);
   assign wr_mask  = wr_en && (bus.address == ADDR_MASK);
   assign wr_force = wr_en && (bus.address == ADDR_FORCE);
   assign wdata    = bus.writedata[NUM_IRQ-1:0];
   assign w1c      = wr_pend ? wdata : '0;
   assign frc_set  = wr_force ? wdata : '0;
   assign unused_wdata = ^bus.writedata;

   // OR-after-clear keeps a FORCE landing with a W1C on the same bit.
   assign soft_pend_d = (soft_pend_q & ~w1c) | frc_set;
   assign mask_d      = wr_mask ? wdata : mask_q;

`ifdef IRQ_CTRL_EDGE_EN
   logic [NUM_IRQ-1:0] irq_prev_q;
   logic [NUM_IRQ-1:0] edge_sel_q, edge_sel_d;
   logic [NUM_IRQ-1:0] rise, edge_chg;
   logic               wr_edge;

   assign wr_edge = wr_en && (bus.address == ADDR_EDGE_SEL);

   always_comb begin
      rise       = irq_in_q & ~irq_prev_q;
      edge_sel_d = wr_edge ? wdata : edge_sel_q;
      edge_chg   = edge_sel_d ^ edge_sel_q;
      hw_pend_d  = ((edge_sel_q & ((hw_pend_q & ~w1c) | rise)) | (~edge_sel_q & irq_in_q))
                   & ~edge_chg;
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         irq_prev_q <= '0;
         edge_sel_q <= '0;
      end else begin
         irq_prev_q <= irq_in_q;
         edge_sel_q <= edge_sel_d;
      end
   end

   assign edge_sel_rd = MAX_IRQ'(edge_sel_q);
`else
   assign hw_pend_d   = irq_in_q;
   assign edge_sel_rd = '0;
`endif

   assign pending = MAX_IRQ'(hw_pend_q | soft_pend_q);
   assign status  = pending & MAX_IRQ'(mask_q);
   assign irq_d   = |status;

   nios_simple_irq_prio_enc u_prio_enc (
      .req_i   (status),
      .valid_o (vec_valid),
      .idx_o   (vec_idx)
   );

   always_comb begin
      readdata_d = '0;
      case (bus.address)
         ADDR_PENDING:  readdata_d = pending;
         ADDR_MASK:     readdata_d = MAX_IRQ'(mask_q);
         ADDR_STATUS:   readdata_d = status;
         ADDR_VECTOR: begin
            readdata_d[VECTOR_VALID_BIT] = vec_valid;
            readdata_d[3:0]              = vec_idx;
         end
         ADDR_EDGE_SEL: readdata_d = edge_sel_rd;
         default:       readdata_d = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         irq_in_q    <= '0;
         hw_pend_q   <= '0;
         soft_pend_q <= '0;
         mask_q      <= '0;
         readdata_q  <= '0;
         irq_q       <= 1'b0;
      end else begin
         irq_in_q    <= irq_in;
         hw_pend_q   <= hw_pend_d;
         soft_pend_q <= soft_pend_d;
         mask_q      <= mask_d;
         readdata_q  <= readdata_d;
         irq_q       <= irq_d;
      end
   end

   assign bus.readdata = readdata_q;
   assign irq          = irq_q;

endmodule

// File: tb/tb_nios_simple_irq_ctrl.sv
// Scoreboard bench for nios_simple_irq_ctrl: directed plan checks plus random
// bus/irq traffic against a behavioural register model.
module tb_nios_simple_irq_ctrl;

   localparam int unsigned NUM_IRQ = 8;
   localparam logic [15:0] VMASK   = 16'h00FF;

   logic               clk;
   logic               reset_n;
   logic [NUM_IRQ-1:0] irq_in;
   logic               irq;

   nios_simple_irq_ctrl_if bus ();

   nios_simple_irq_ctrl #(.NUM_IRQ(NUM_IRQ)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .irq_in  (irq_in),
      .bus     (bus),
      .irq     (irq)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      bit          is_irq;
      logic [15:0] exp;
      string       name;
   } sb_t;

   sb_t sb[$];
   int  n_cmp = 0;
   int  n_bad = 0;

   // One-shot extra constant expectation, consumed at the next rising edge.
   bit          k_en = 0;
   bit          k_irq;
   logic [15:0] k_val;
   string       k_name;

   // Behavioural model state (16-bit, bits above NUM_IRQ stay zero).
   logic [15:0] m_in_q, m_prev, m_hw, m_soft, m_mask, m_edge;

   always @(posedge clk) begin
      logic [15:0] pend, stat, exp_rd, wd, n_hw, n_soft;
      logic        wr, found;
      if (!reset_n) begin
         sb.push_back('{0, 16'h0000, "readdata"});
         sb.push_back('{1, 16'h0000, "irq"});
         m_in_q = 0; m_prev = 0; m_hw = 0; m_soft = 0; m_mask = 0; m_edge = 0;
      end else begin
         pend = m_hw | m_soft;
         stat = pend & m_mask;
         case (bus.address)
            3'd0: exp_rd = pend;
            3'd1: exp_rd = m_mask;
            3'd2: exp_rd = stat;
            3'd3: begin
               exp_rd = 0;
               found  = 0;
               for (int i = 0; i < 16; i++) begin
                  if (!found && stat[i]) begin
                     exp_rd = 16'h8000 | 16'(i);
                     found  = 1;
                  end
               end
            end
            3'd4: exp_rd = m_edge;
            default: exp_rd = 0;
         endcase
         sb.push_back('{0, exp_rd, "readdata"});
         sb.push_back('{1, {15'b0, (stat != 0)}, "irq"});

         wr = bus.chipselect && !bus.write_n;
         wd = bus.writedata & VMASK;
         n_soft = m_soft;
         for (int i = 0; i < 16; i++) begin
            if (wr && bus.address == 3'd0 && wd[i]) n_soft[i] = 0;
            if (wr && bus.address == 3'd5 && wd[i]) n_soft[i] = 1;
`ifdef IRQ_CTRL_EDGE_EN
            if (m_edge[i]) begin
               n_hw[i] = m_hw[i];
               if (wr && bus.address == 3'd0 && wd[i]) n_hw[i] = 0;
               if (m_in_q[i] && !m_prev[i]) n_hw[i] = 1;
            end else begin
               n_hw[i] = m_in_q[i];
            end
            if (wr && bus.address == 3'd4 && (wd[i] != m_edge[i])) n_hw[i] = 0;
`else
            n_hw[i] = m_in_q[i];
`endif
         end
         m_hw   = n_hw;
         m_soft = n_soft;
         if (wr && bus.address == 3'd1) m_mask = wd;
`ifdef IRQ_CTRL_EDGE_EN
         if (wr && bus.address == 3'd4) m_edge = wd;
`endif
         m_prev = m_in_q;
         m_in_q = {8'b0, irq_in};
      end
      if (k_en) begin
         sb.push_back('{k_irq, k_val, k_name});
         k_en = 0;
      end
   end

   // Monitor: everything pushed at a rising edge is checked on the falling edge.
   always @(negedge clk) begin
      sb_t         e;
      logic [15:0] act;
      while (sb.size() > 0) begin
         e   = sb.pop_front();
         act = e.is_irq ? {15'b0, irq} : bus.readdata;
         n_cmp++;
         if (act !== e.exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", e.name, act, e.exp, $time);
         end
      end
   end

   // Watchdog: the directed and random sequences must finish well before this.
   initial begin
      #2000000;
      n_bad++;
      $display("FAIL timeout: wait expired at %0t", $time);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge clk);
   endtask

   task automatic check_now(input logic [15:0] act, input logic [15:0] exp,
                            input string nm);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic expect_next(input bit is_irq, input logic [15:0] v, input string nm);
      k_en   = 1;
      k_irq  = is_irq;
      k_val  = v;
      k_name = nm;
   endtask

   task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
      bus.address    = a;
      bus.writedata  = d;
      bus.chipselect = 1;
      bus.write_n    = 0;
      tick();
      bus.chipselect = 0;
      bus.write_n    = 1;
   endtask

   initial begin
      reset_n        = 0;
      irq_in         = 8'hFF;
      bus.address    = 0;
      bus.chipselect = 0;
      bus.write_n    = 1;
      bus.writedata  = 0;

      // Reset with all sources high.
      tick();
      expect_next(0, 16'h0000, "reset_readdata");
      tick();
      expect_next(1, 16'h0000, "reset_irq");
      check_now(bus.readdata, 16'h0000, "reset_state_readdata");
      check_now({15'b0, irq}, 16'h0000, "reset_state_irq");
      reset_n = 1;
      tick(4);
      expect_next(0, 16'h00FF, "pending_after_reset");
      tick();
      expect_next(1, 16'h0000, "irq_masked_after_reset");
      tick();

      // Level path.
      irq_in = 0;
      bus_wr(3'd1, 16'h0001);
      tick(4);
      irq_in = 8'h01;
      tick(4);
      expect_next(1, 16'h0001, "level_irq_high");
      tick();
      irq_in = 0;
      tick(3);
      expect_next(1, 16'h0000, "level_irq_low");
      tick();
      irq_in = 8'h01;
      tick(4);
      bus_wr(3'd0, 16'h0001);
      tick();
      expect_next(0, 16'h0001, "level_w1c_holds");
      tick();

      // Vector.
      bus_wr(3'd1, 16'h00FF);
      irq_in      = 8'b1010_0000;
      bus.address = 3'd3;
      tick(4);
      expect_next(0, 16'h8005, "vector_lowest");
      tick();
      irq_in = 0;
      tick(4);
      expect_next(0, 16'h0000, "vector_none");
      tick();

`ifdef IRQ_CTRL_EDGE_EN
      // Edge mode on source 1.
      bus_wr(3'd4, 16'h0002);
      bus.address = 3'd0;
      tick(3);
      irq_in = 8'h02;
      tick();
      irq_in = 0;
      tick(4);
      expect_next(0, 16'h0002, "edge_held");
      tick();
      bus_wr(3'd0, 16'h0002);
      tick();
      expect_next(0, 16'h0000, "edge_w1c_clears");
      tick();
      irq_in = 8'h02;
      tick(4);
      irq_in = 0;
      tick(4);
      irq_in = 8'h02;
      tick();
      irq_in = 0;
      bus_wr(3'd0, 16'h0002);
      tick(2);
      expect_next(0, 16'h0002, "edge_set_beats_w1c");
      tick();
      bus_wr(3'd0, 16'h0002);
      tick(2);
`endif

      // FORCE.
      irq_in = 0;
      bus_wr(3'd1, 16'h0080);
      tick(4);
      bus_wr(3'd5, 16'h0080);
      tick();
      expect_next(1, 16'h0001, "force_irq_high");
      tick();
      bus_wr(3'd0, 16'h0080);
      expect_next(1, 16'h0000, "force_w1c_irq_low");
      tick();

      // Reset mid-operation.
      bus_wr(3'd1, 16'h000F);
      irq_in = 8'h0F;
      tick(4);
      expect_next(1, 16'h0001, "midop_irq_high");
      tick();
      reset_n = 0;
      expect_next(1, 16'h0000, "midop_reset_irq");
      tick();
      check_now({15'b0, irq}, 16'h0000, "midop_reset_state_irq");
      reset_n     = 1;
      bus.address = 3'd1;
      tick();
      expect_next(0, 16'h0000, "midop_mask_cleared");
      tick();
      bus.address = 3'd0;
      tick(4);

      // Random traffic.
      for (int n = 0; n < 3000; n++) begin
         reset_n        = ($urandom_range(0, 199) != 0);
         irq_in         = 8'($urandom);
         bus.address    = 3'($urandom);
         bus.chipselect = 1'($urandom);
         bus.write_n    = ($urandom_range(0, 2) != 0);
         bus.writedata  = 16'($urandom);
         tick();
      end
      reset_n        = 1;
      bus.chipselect = 0;
      bus.write_n    = 1;
      tick(2);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
